// File: rtl/pad_share_arbiter.sv
// Round-robin owner of a single bidirectional pad cell.
// Forwards the owner's enable/data/config to the pad one cycle registered and
// inserts a high-Z turnaround window after each grant ends. The pad input is
// synchronised and broadcast to every requester.
module pad_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TURN_CYC    = 2,
   parameter int MAX_HOLD    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] oe_i,
   input  logic [NUM_REQ-1:0] out_i,
   input  logic [NUM_REQ-1:0] cfg_drv_i,
   input  logic [NUM_REQ-1:0] cfg_slw_i,
   input  logic [NUM_REQ-1:0] cfg_smt_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               in_o,
   output logic               busy_o,
   output logic               pad_oen_o,
   output logic               pad_out_o,
   input  logic               pad_in_i,
   output logic               pad_drv_o,
   output logic               pad_slw_o,
   output logic               pad_smt_o
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   // Counters keep at least one bit so a zero parameter still elaborates.
   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TURN_W = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

   localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
   localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

   state_t              r_state;
   logic [PTR_W-1:0]    r_owner;
   logic [PTR_W-1:0]    r_rr_ptr;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [TURN_W-1:0]   r_turn_cnt;
   logic [NUM_REQ-1:0]  r_gnt;
   logic                r_pad_oen;
   logic                r_pad_out;
   logic                r_pad_drv;
   logic                r_pad_slw;
   logic                r_pad_smt;
   logic [SYNC_STAGES-1:0] r_sync;

   state_t              w_state_next;
   logic [PTR_W-1:0]    w_owner_next;
   logic [PTR_W-1:0]    w_rr_ptr_next;
   logic [HOLD_W-1:0]   w_hold_cnt_next;
   logic [TURN_W-1:0]   w_turn_cnt_next;
   logic [NUM_REQ-1:0]  w_gnt_next;
   logic                w_pad_oen_next;
   logic                w_pad_out_next;
   logic                w_pad_drv_next;
   logic                w_pad_slw_next;
   logic                w_pad_smt_next;

   logic [2*NUM_REQ-1:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic                 w_found;
   logic [PTR_W-1:0]     w_offset;
   logic [PTR_W:0]       w_sum;
   logic [PTR_W-1:0]     w_winner;
   logic [NUM_REQ-1:0]   w_owner_mask;
   logic                 w_other_req;
   logic                 w_release;

   // Rotate requests so bit 0 is the requester at rr_ptr; the first set bit wins.
   assign w_req_dbl    = {req_i, req_i};
   assign w_req_rot    = w_req_dbl[r_rr_ptr +: NUM_REQ];
   assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_offset};
   assign w_winner     = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
   assign w_owner_mask = NUM_REQ'(1) << r_owner;
   assign w_other_req  = |(req_i & ~w_owner_mask);

   // Find the lowest set bit of the rotated request vector.
   always_comb begin
      w_found  = 1'b0;
      w_offset = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_found  = 1'b1;
            w_offset = PTR_W'(k);
         end
      end
   end

   // Owner gives up, or is revoked after its hold budget while someone waits.
   assign w_release = !req_i[r_owner] ||
                      ((MAX_HOLD != 0) && (r_hold_cnt >= HOLD_LIM) && w_other_req);

   // Next-state and registered-output decode.
   always_comb begin
      w_state_next    = r_state;
      w_owner_next    = r_owner;
      w_rr_ptr_next   = r_rr_ptr;
      w_hold_cnt_next = r_hold_cnt;
      w_turn_cnt_next = r_turn_cnt;
      w_gnt_next      = r_gnt;
      w_pad_oen_next  = 1'b1;
      w_pad_out_next  = 1'b0;
      w_pad_drv_next  = 1'b0;
      w_pad_slw_next  = 1'b0;
      w_pad_smt_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_gnt_next = '0;
            if (w_found) begin
               w_state_next    = ST_GRANT;
               w_owner_next    = w_winner;
               w_gnt_next      = NUM_REQ'(1) << w_winner;
               w_hold_cnt_next = '0;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_rr_ptr_next   = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
               w_hold_cnt_next = '0;
               w_turn_cnt_next = '0;
               w_gnt_next      = '0;
               w_state_next    = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
            end else begin
               w_pad_oen_next  = ~oe_i[r_owner];
               w_pad_out_next  = out_i[r_owner];
               w_pad_drv_next  = cfg_drv_i[r_owner];
               w_pad_slw_next  = cfg_slw_i[r_owner];
               w_pad_smt_next  = cfg_smt_i[r_owner];
               if (r_hold_cnt != HOLD_SAT) begin
                  w_hold_cnt_next = r_hold_cnt + 1'b1;
               end
            end
         end
         ST_TURN: begin
            w_gnt_next = '0;
            if (r_turn_cnt == TURN_LAST) begin
               w_turn_cnt_next = '0;
               w_state_next    = ST_IDLE;
            end else begin
               w_turn_cnt_next = r_turn_cnt + 1'b1;
            end
         end
         default: begin
            w_gnt_next   = '0;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and pad registers; reset releases the pad immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
         r_turn_cnt <= '0;
         r_gnt      <= '0;
         r_pad_oen  <= 1'b1;
         r_pad_out  <= 1'b0;
         r_pad_drv  <= 1'b0;
         r_pad_slw  <= 1'b0;
         r_pad_smt  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_owner    <= w_owner_next;
         r_rr_ptr   <= w_rr_ptr_next;
         r_hold_cnt <= w_hold_cnt_next;
         r_turn_cnt <= w_turn_cnt_next;
         r_gnt      <= w_gnt_next;
         r_pad_oen  <= w_pad_oen_next;
         r_pad_out  <= w_pad_out_next;
         r_pad_drv  <= w_pad_drv_next;
         r_pad_slw  <= w_pad_slw_next;
         r_pad_smt  <= w_pad_smt_next;
      end
   end

   // Pad input synchroniser, running in every state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in_i};
      end
   end

   assign gnt_o     = r_gnt;
   assign in_o      = r_sync[SYNC_STAGES-1];
   assign busy_o    = (r_state != ST_IDLE);
   assign pad_oen_o = r_pad_oen;
   assign pad_out_o = r_pad_out;
   assign pad_drv_o = r_pad_drv;
   assign pad_slw_o = r_pad_slw;
   assign pad_smt_o = r_pad_smt;

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Directed bench for pad_share_arbiter: one bounded-hold instance and one
// unlimited-hold instance sharing clock, reset and pad input.
module tb_pad_share_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0, req_u = '0, oe = '0, out_d = '0;
   logic [3:0] drv = '0, slw = '0, smt = '0;
   logic       pad_in = 1'b0;

   logic [3:0] gnt, gnt_u;
   logic       in_o, busy, pad_oen, pad_out, pad_drv, pad_slw, pad_smt;
   logic       in_u, busy_u, oen_u, out_u, drv_u, slw_u, smt_u;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pad_share_arbiter #(.NUM_REQ(4), .TURN_CYC(2), .MAX_HOLD(4), .SYNC_STAGES(2)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .oe_i(oe), .out_i(out_d),
      .cfg_drv_i(drv), .cfg_slw_i(slw), .cfg_smt_i(smt),
      .gnt_o(gnt), .in_o(in_o), .busy_o(busy), .pad_oen_o(pad_oen),
      .pad_out_o(pad_out), .pad_in_i(pad_in), .pad_drv_o(pad_drv),
      .pad_slw_o(pad_slw), .pad_smt_o(pad_smt)
   );

   pad_share_arbiter #(.NUM_REQ(4), .TURN_CYC(2), .MAX_HOLD(0), .SYNC_STAGES(2)) u_unl (
      .clk_i(clk), .rst_i(rst), .req_i(req_u), .oe_i(oe), .out_i(out_d),
      .cfg_drv_i(drv), .cfg_slw_i(slw), .cfg_smt_i(smt),
      .gnt_o(gnt_u), .in_o(in_u), .busy_o(busy_u), .pad_oen_o(oen_u),
      .pad_out_o(out_u), .pad_in_i(pad_in), .pad_drv_o(drv_u),
      .pad_slw_o(slw_u), .pad_smt_o(smt_u)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      pad_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({pad_oen, pad_out, gnt, busy, in_o, pad_drv, pad_slw, pad_smt} !== 11'b1_0_0000_0_0_000) begin
         failures++;
         $display("FAIL reset_state got oen=%b out=%b gnt=%b busy=%b in=%b cfg=%b%b%b want oen=1 rest 0",
                  pad_oen, pad_out, gnt, busy, in_o, pad_drv, pad_slw, pad_smt);
      end
      pad_in = 1'b0;
      rst = 1'b0;
      repeat (3) tick();
      $display("reset: oen=%b gnt=%b in=%b", pad_oen, gnt, in_o);
   endtask

   task automatic test_mid_reset();
      req = 4'b0001; oe = 4'b0001; out_d = 4'b0001; drv = 4'b0001;
      tick();
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         failures++;
         $display("FAIL grant_latency got gnt=%b busy=%b want gnt=0001 busy=1", gnt, busy);
      end
      tick();
      checks++;
      if ({pad_oen, pad_out, pad_drv} !== 3'b011) begin
         failures++;
         $display("FAIL owner_drive got oen=%b out=%b drv=%b want 0 1 1", pad_oen, pad_out, pad_drv);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pad_oen, pad_out, pad_drv, gnt, busy} !== 8'b1_0_0_0000_0) begin
         failures++;
         $display("FAIL mid_reset got oen=%b out=%b drv=%b gnt=%b busy=%b want oen=1 rest 0",
                  pad_oen, pad_out, pad_drv, gnt, busy);
      end
      req = 4'b0000; oe = '0; out_d = '0; drv = '0;
      tick();
      rst = 1'b0;
      req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         failures++;
         $display("FAIL post_reset_grant got gnt=%b want 1000", gnt);
      end
      $display("mid_reset: post-reset gnt=%b", gnt);
      req = 4'b0000;
      repeat (4) tick();
   endtask

   task automatic test_round_robin();
      int phase, owner;
      logic [3:0] exp_gnt;
      logic exp_oen, exp_out;
      oe = 4'b1111; out_d = 4'b0101;
      req = 4'b1111;
      for (int k = 1; k <= 35; k++) begin
         tick();
         phase = (k - 1) % 7;
         owner = ((k - 1) / 7) % 4;
         exp_gnt = (phase < 4) ? (4'b0001 << owner) : 4'b0000;
         exp_oen = (phase >= 1 && phase <= 3) ? 1'b0 : 1'b1;
         exp_out = (phase >= 1 && phase <= 3) ? out_d[owner] : 1'b0;
         checks++;
         if (gnt !== exp_gnt || pad_oen !== exp_oen || pad_out !== exp_out) begin
            failures++;
            $display("FAIL round_robin cyc=%0d got gnt=%b oen=%b out=%b want gnt=%b oen=%b out=%b",
                     k, gnt, pad_oen, pad_out, exp_gnt, exp_oen, exp_out);
         end
      end
      $display("round_robin: 5 grants observed, last gnt=%b", gnt);
      req = 4'b0000; oe = '0; out_d = '0;
      repeat (3) tick();
   endtask

   task automatic test_turnaround();
      int hiz;
      oe = 4'b0001; out_d = 4'b0001;
      req = 4'b0001;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL turn_grant0 got gnt=%b want 0001", gnt);
      end
      req = 4'b0011;
      tick();
      checks++;
      if (pad_oen !== 1'b0 || pad_out !== 1'b1) begin
         failures++;
         $display("FAIL turn_drive got oen=%b out=%b want 0 1", pad_oen, pad_out);
      end
      tick();
      req = 4'b0010;
      tick();
      checks++;
      if (gnt !== 4'b0000 || pad_oen !== 1'b1 || pad_out !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL release got gnt=%b oen=%b out=%b busy=%b want 0000 1 0 1", gnt, pad_oen, pad_out, busy);
      end
      hiz = 1;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (gnt !== 4'b0000) break;
         if (pad_oen === 1'b1) hiz++;
      end
      checks++;
      if (gnt !== 4'b0010 || hiz != 3 || pad_oen !== 1'b1) begin
         failures++;
         $display("FAIL turnaround got gnt=%b hiz=%0d oen=%b want gnt=0010 hiz=3 oen=1", gnt, hiz, pad_oen);
      end
      $display("turnaround: hiz cycles=%0d next gnt=%b", hiz, gnt);
      req = 4'b0000; oe = '0; out_d = '0;
      repeat (5) tick();
   endtask

   task automatic test_simultaneous();
      int gap;
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL sim_grant2 got gnt=%b want 0100", gnt);
      end
      req = 4'b1110;
      repeat (3) tick();
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL sim_early_revoke got gnt=%b want 0100", gnt);
      end
      req = 4'b1010;
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL sim_release got gnt=%b busy=%b want 0000 1", gnt, busy);
      end
      gap = 1;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (gnt !== 4'b0000) break;
         gap++;
      end
      checks++;
      if (gnt !== 4'b1000 || gap != 3) begin
         failures++;
         $display("FAIL sim_single_release got gnt=%b gap=%0d want gnt=1000 gap=3", gnt, gap);
      end
      $display("simultaneous: gap=%0d next gnt=%b", gap, gnt);
      req = 4'b0000;
      repeat (5) tick();
   endtask

   task automatic test_unlimited_hold();
      int bad, lat;
      req_u = 4'b0100;
      tick();
      checks++;
      if (gnt_u !== 4'b0100) begin
         failures++;
         $display("FAIL unl_grant got gnt=%b want 0100", gnt_u);
      end
      req_u = 4'b0101;
      bad = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (gnt_u !== 4'b0100) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL unl_no_revoke got %0d lost-grant cycles want 0", bad);
      end
      req_u = 4'b0001;
      lat = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         lat++;
         if (gnt_u !== 4'b0000) break;
      end
      checks++;
      if (gnt_u !== 4'b0001 || lat != 4) begin
         failures++;
         $display("FAIL unl_handover got gnt=%b lat=%0d want gnt=0001 lat=4", gnt_u, lat);
      end
      $display("unlimited_hold: handover latency=%0d gnt=%b", lat, gnt_u);
      req_u = 4'b0000;
      repeat (5) tick();
   endtask

   task automatic test_sync();
      logic exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic drv_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int n = 0; n < 4; n++) begin
         pad_in = drv_seq[n];
         tick();
         checks++;
         if (in_o !== exp_seq[n] || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL sync step=%0d got in=%b gnt=%b want in=%b gnt=0000", n, in_o, gnt, exp_seq[n]);
         end
         $display("sync: step=%0d pad_in=%b in_o=%b", n, pad_in, in_o);
      end
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_round_robin();
      test_turnaround();
      test_simultaneous();
      test_unlimited_hold();
      test_sync();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pad_share_arbiter.md
# pad_share_arbiter

Time-shares one bidirectional pad cell between `NUM_REQ` on-chip requesters. It grants ownership round-robin and forwards the owner's output-enable, data and drive configuration to the pad. On every ownership change or release it inserts a guaranteed high-Z turnaround window. It also returns a synchronized copy of the pad input to all requesters. The block sits between the peripheral pad-mux and a single pad instance, so the pad is never driven by two sources and never switches direction without a bus-release gap.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `TURN_CYC`, 2: high-Z cycles inserted after every grant ends; 0 = none.
- `MAX_HOLD`, 16: maximum grant length in cycles while another requester waits; 0 = unlimited.
- `SYNC_STAGES`, 2: flops in the pad-input synchronizer; must be ≥2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Asynchronous and active-high.
- `req_i` in NUM_REQ: per-requester ownership request, level, held for the whole transfer.
- `oe_i` in NUM_REQ: per-requester drive enable; 1 = drive pad.
- `out_i` in NUM_REQ: per-requester output data.
- `cfg_drv_i`, `cfg_slw_i`, `cfg_smt_i` in NUM_REQ each: per-requester pad drive-strength, slew and Schmitt settings.
- `gnt_o` out NUM_REQ: one-hot grant, registered.
- `in_o` out 1: synchronized pad input, broadcast to all requesters.
- `busy_o` out 1: high in GRANT or TURN.
- `pad_oen_o` out 1: to pad OEN; 1 = high-Z.
- `pad_out_o` out 1: to pad I.
- `pad_in_i` in 1: from pad O.
- `pad_drv_o`, `pad_slw_o`, `pad_smt_o` out 1: to pad DRV, SLW and SMT.

## Operation
- State machine: IDLE, GRANT, TURN.
- **IDLE**
  - Outputs: `pad_oen_o`=1, `pad_out_o`=0, cfg outputs 0, `gnt_o`=0.
  - If any `req_i` is set, the winner is the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ. The block records it as owner and moves to GRANT.
- **GRANT**
  - `gnt_o[owner]`=1.
  - Every cycle the block registers `pad_oen_o`←~`oe_i[owner]`, `pad_out_o`←`out_i[owner]` and cfg outputs←`cfg_*_i[owner]`.
  - The hold counter increments each GRANT cycle.
  - The grant ends when `req_i[owner]`=0. It also ends when MAX_HOLD≠0, the counter has reached MAX_HOLD−1 and another `req_i` bit is set. When both conditions are true in the same cycle, the block takes the same release path.
  - On exit: `rr_ptr`←(owner+1) mod NUM_REQ, hold counter cleared, `gnt_o`←0, `pad_oen_o`←1, `pad_out_o`←0, cfg outputs←0.
  - Next state is TURN if TURN_CYC>0, otherwise IDLE.
- **TURN**
  - Outputs as in IDLE.
  - The counter runs for TURN_CYC cycles, then the block moves to IDLE.
  - Requests are ignored until IDLE.
- **Requester rules**
  - A requester whose grant is revoked sees `gnt_o` fall while `req_i` is still high. It must treat its transfer as aborted and may keep requesting.
  - Toggling `oe_i[owner]` during GRANT changes pad direction with no turnaround gap. The requester owns that timing.
- **Widths and counters**
  - `rr_ptr` is $clog2(NUM_REQ) bits.
  - The hold counter is $clog2(MAX_HOLD+1) bits and saturates.
  - The turn counter is $clog2(TURN_CYC+1) bits.
- **Synchronizer:** `pad_in_i` passes through SYNC_STAGES flops to `in_o` in every state.
- **Reset:** asynchronous `rst_i` immediately forces:
  - state IDLE, `pad_oen_o`=1
  - `pad_out_o`, `gnt_o`, cfg outputs, `busy_o`, `in_o` = 0
  - `rr_ptr`, all counters and all synchronizer flops = 0
- **Mid-transfer reset:** the pad is released in the same cycle, with no turnaround.

## Timing
- Grant latency from IDLE: `req_i` set at edge t gives `gnt_o` at t+1. The pad reflects the owner's `oe_i`/`out_i` from t+2.
- `oe_i`/`out_i`/cfg to pad: 1 cycle registered.
- Release: `req_i[owner]` low at t gives `gnt_o`=0 and `pad_oen_o`=1 at t+1. The next grant is at t+2+TURN_CYC at the earliest.
- Back-to-back owners are always separated by ≥TURN_CYC+1 cycles of `pad_oen_o`=1.
- `in_o` latency: SYNC_STAGES cycles.

## Test plan
- **Reset release:** drive `rst_i` high mid-GRANT with owner driving. Required: `pad_oen_o`=1 and `gnt_o`=0 in the same cycle. After reset, the first request from req 3 alone gets `gnt_o`=4'b1000 one cycle later.
- **Round-robin:** NUM_REQ=4, `req_i`=4'b1111 held, MAX_HOLD=4. Required: grant order 0,1,2,3,0, each grant exactly 4 cycles, each followed by 2 high-Z cycles.
- **Turnaround:** req0 drives `out_i[0]`=1 with `oe_i[0]`=1, then drops; req1 is waiting. Required: `pad_oen_o`=1 for exactly 3 cycles (release cycle plus TURN_CYC=2) before `gnt_o[1]`.
- **Unlimited hold:** MAX_HOLD=0, req2 holds 100 cycles while req0 waits. Required: no revoke; req0 is granted 2+TURN_CYC cycles after req2 drops.
- **Simultaneous drop/timeout:** owner drops `req_i` in the revoke cycle. Required: a single release, `rr_ptr`=owner+1, no double TURN.
- **Synchronizer:** toggle `pad_in_i` with no grant. Required: `in_o` follows after exactly 2 cycles.
